// File: rtl/sram_fifo_ctrl_if.sv
// Push/pop stream and status bundle for sram_fifo_ctrl.
// The master side produces pushes and consumes pops; the slave side is the FIFO.
interface sram_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  flush;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;

  modport master (
    output wr_valid,
    output wr_data,
    output rd_ready,
    output flush,
    input  wr_ready,
    input  rd_valid,
    input  rd_data,
    input  count,
    input  full,
    input  empty
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  rd_ready,
    input  flush,
    output wr_ready,
    output rd_valid,
    output rd_data,
    output count,
    output full,
    output empty
  );

endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller backed by an external 1W/1R SRAM with a one-cycle read latency.
// Words live in SRAM until read-issued; read data lands in a 2-entry output
// buffer so the consumer sees registered rd_valid/rd_data and full throughput.
module sram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_fifo_ctrl_if.slave       bus,
  output logic                  sram_csb0,
  output logic [3:0]            sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int CntW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   DepthCnt = CntW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    BufEmpty,
    BufOne,
    BufTwo
  } buf_state_e;

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  // Entries sitting in SRAM that have not yet been read-issued.
  logic [ADDR_WIDTH:0]   mem_cnt;
  // A read was issued last cycle; its data is on sram_dout1 now.
  logic                  inflight;
  buf_state_e            buf_state;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;

  logic       push;
  logic       pop;
  logic       issue;
  logic       capture;
  logic [1:0] buf_cnt;
  logic [2:0] occ;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LastAddr) ? '0 : p + 1'b1;
  endfunction

  // Decode buffer occupancy from the buffer state.
  always_comb begin
    buf_cnt = 2'd0;
    unique case (buf_state)
      BufEmpty: buf_cnt = 2'd0;
      BufOne:   buf_cnt = 2'd1;
      BufTwo:   buf_cnt = 2'd2;
      default:  buf_cnt = 2'd0;
    endcase
  end

  // Handshakes and read-issue decision; flush suppresses every SRAM access.
  always_comb begin
    bus.wr_ready = !bus.flush && (mem_cnt != DepthCnt);
    push         = bus.wr_valid && bus.wr_ready;
    pop          = bus.rd_valid && bus.rd_ready && !bus.flush;
    occ          = {1'b0, buf_cnt} + {2'b00, inflight};
    // Only read what is already counted in mem_cnt, so a same-cycle push is never read back.
    issue        = (mem_cnt != '0) && !bus.flush && (occ < (3'd2 + {2'b00, pop}));
    capture      = inflight && !bus.flush;
  end

  // SRAM port drive; both ports are combinational from this cycle's decisions.
  always_comb begin
    sram_csb0   = !push;
    sram_wmask0 = push ? 4'hF : 4'h0;
    sram_addr0  = wptr;
    sram_din0   = bus.wr_data;
    sram_csb1   = !issue;
    sram_addr1  = rptr;
  end

  // Pointers, SRAM occupancy and the in-flight read stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else if (bus.flush) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (push) begin
        wptr <= ptr_inc(wptr);
      end
      if (issue) begin
        rptr <= ptr_inc(rptr);
      end
      unique case ({push, issue})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase
      inflight <= issue;
    end
  end

  // Output buffer FSM: buf0 is always the head word, buf1 the one behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_state <= BufEmpty;
      buf0      <= '0;
      buf1      <= '0;
    end else if (bus.flush) begin
      buf_state <= BufEmpty;
    end else begin
      unique case (buf_state)
        BufEmpty: begin
          if (capture) begin
            buf0      <= sram_dout1;
            buf_state <= BufOne;
          end
        end
        BufOne: begin
          if (capture && pop) begin
            buf0 <= sram_dout1;
          end else if (capture) begin
            buf1      <= sram_dout1;
            buf_state <= BufTwo;
          end else if (pop) begin
            buf_state <= BufEmpty;
          end
        end
        BufTwo: begin
          if (pop) begin
            buf0 <= buf1;
            // Issue throttling keeps capture out of this state; handled anyway.
            if (capture) begin
              buf1 <= sram_dout1;
            end else begin
              buf_state <= BufOne;
            end
          end
        end
        default: buf_state <= BufEmpty;
      endcase
    end
  end

  // Status outputs, all derived from registered state.
  always_comb begin
    bus.rd_valid = (buf_state != BufEmpty);
    bus.rd_data  = buf0;
    bus.count    = mem_cnt + CntW'(inflight) + CntW'(buf_cnt);
    bus.full     = (mem_cnt == DepthCnt);
    bus.empty    = (bus.count == '0);
  end

  // Two buffer slots plus one in-flight read must never overflow.
  assert property (@(posedge clk) disable iff (rst) !(buf_state == BufTwo && capture && !pop));

  // Occupancy can never exceed SRAM depth plus the two buffer slots.
  assert property (@(posedge clk) disable iff (rst) bus.count <= DepthCnt + CntW'(2));

endmodule
